// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues one-at-a-time imem requests, buffers {pc, word} for predictor/decode.
// Latency: request -> response >= 1 cycle, pushed word is visible at the head the cycle after the response.
// Backpressure: no request while the buffer is full; fetch_ready stalls the head. FETCH_PERF_CTR_EN adds perf counters.

`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 64
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 32
`endif

// fifo: generic circular buffer with synchronous flush; head is combinational.
// Latency: push visible on the next cycle. Backpressure: caller must not push when full.
// Pop and push in the same cycle keep the count unchanged.
module fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // Storage needs no reset: the consumer gates the head with its own valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign pop_data = mem[rd_ptr];
endmodule

module fetch_unit #(
  parameter logic [`ADDRESS_SIZE-1:0] RESET_PC   = '0,
  parameter int                       FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [`ADDRESS_SIZE-1:0]     imem_req_addr,
  input  logic                         imem_resp_valid,
  input  logic [`INSTRUCTION_SIZE-1:0] imem_resp_data,
  output logic                         fetch_valid,
  input  logic                         fetch_ready,
  output logic [`ADDRESS_SIZE-1:0]     fetch_pc,
  output logic [`INSTRUCTION_SIZE-1:0] fetch_instruction,
  input  logic                         pred_overwrite_pc,
  input  logic [`ADDRESS_SIZE-1:0]     pred_next_pc,
  input  logic                         redirect_valid,
  input  logic [`ADDRESS_SIZE-1:0]     redirect_pc
`ifdef FETCH_PERF_CTR_EN
  ,
  output logic [31:0]                  perf_fetched,
  output logic [31:0]                  perf_redirects
`endif
);
  localparam int AW = `ADDRESS_SIZE;
  localparam int IW = `INSTRUCTION_SIZE;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] ALIGN_MASK = {{(AW-2){1'b1}}, 2'b00};

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instruction;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] pc_reg;
  logic [AW-1:0] req_pc;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic [CW-1:0] count;
  logic          pop;
  logic          pred_redirect;
  logic          any_redirect;
  logic          issue;
  logic          push;

  // Execute redirect wins over both the pop and any predictor redirect.
  assign fetch_valid   = (count != '0);
  assign pop           = fetch_valid && fetch_ready && !redirect_valid;
  assign pred_redirect = pop && pred_overwrite_pc;
  assign any_redirect  = redirect_valid || pred_redirect;
  assign issue         = imem_req_valid && imem_req_ready;

  assign imem_req_addr     = pc_reg;
  assign fetch_pc          = fetch_valid ? head.pc : '0;
  assign fetch_instruction = fetch_valid ? head.instruction : '0;
  assign push_entry        = '{pc: req_pc, instruction: imem_resp_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    push           = 1'b0;
    case (state)
      S_IDLE: begin
        imem_req_valid = !reset && (count < DEPTH_C) && !any_redirect;
        if (imem_req_valid && imem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response landing with a redirect belongs to the old path.
        if (imem_resp_valid) begin
          push      = !any_redirect;
          state_nxt = S_IDLE;
        end else if (any_redirect) begin
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_resp_valid) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg <= RESET_PC;
      req_pc <= '0;
    end else if (redirect_valid) begin
      pc_reg <= redirect_pc & ALIGN_MASK;
    end else if (pred_redirect) begin
      pc_reg <= pred_next_pc & ALIGN_MASK;
    end else if (issue) begin
      pc_reg <= pc_reg + AW'(4);
      req_pc <= pc_reg;
    end
  end

  fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (any_redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (count)
  );

`ifdef FETCH_PERF_CTR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
    end else begin
      if (pop && (perf_fetched != '1)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (any_redirect && (perf_redirects != '1)) begin
        perf_redirects <= perf_redirects + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven reset/fetch vectors, directed redirect corner cases and a randomized
// run, all checked every cycle against a queue-based reference model of the fetch stage.
module tb_fetch_unit;
  localparam int AW    = 64;
  localparam int IW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b0;
  logic [AW-1:0] imem_req_addr;
  logic          imem_resp_valid = 1'b0;
  logic [IW-1:0] imem_resp_data = '0;
  logic          fetch_valid;
  logic          fetch_ready = 1'b0;
  logic [AW-1:0] fetch_pc;
  logic [IW-1:0] fetch_instruction;
  logic          pred_overwrite_pc = 1'b0;
  logic [AW-1:0] pred_next_pc = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
`ifdef FETCH_PERF_CTR_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_redirects;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (64'h0),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_req_addr     (imem_req_addr),
    .imem_resp_valid   (imem_resp_valid),
    .imem_resp_data    (imem_resp_data),
    .fetch_valid       (fetch_valid),
    .fetch_ready       (fetch_ready),
    .fetch_pc          (fetch_pc),
    .fetch_instruction (fetch_instruction),
    .pred_overwrite_pc (pred_overwrite_pc),
    .pred_next_pc      (pred_next_pc),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc)
`ifdef FETCH_PERF_CTR_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_redirects    (perf_redirects)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the fetch buffer as a queue, plus one in-flight request that is kept or discarded.
  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] ins;
  } ent_t;

  ent_t            mq[$];
  logic [AW-1:0]   m_pc;
  logic [AW-1:0]   m_out_addr;
  bit              m_inflight;
  bit              m_keep;
  longint unsigned m_fetched;
  longint unsigned m_redirs;

  logic          obs_req_v;
  logic [AW-1:0] obs_addr;
  logic          obs_fv;
  logic [AW-1:0] obs_fpc;
  logic [IW-1:0] obs_ins;

  function automatic logic [31:0] sat32(input longint unsigned v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc       = '0;
    m_out_addr = '0;
    m_inflight = 1'b0;
    m_keep     = 1'b0;
    m_fetched  = 0;
    m_redirs   = 0;
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic cyc(input bit rr, input bit rsp, input logic [IW-1:0] dat, input bit fr,
                     input bit po, input logic [AW-1:0] ppc, input bit rv, input logic [AW-1:0] rpc);
    bit fv, popq, pred, anyr, reqv, pushq;
    @(negedge clk);
    imem_req_ready    = rr;
    imem_resp_valid   = rsp;
    imem_resp_data    = dat;
    fetch_ready       = fr;
    pred_overwrite_pc = po;
    pred_next_pc      = ppc;
    redirect_valid    = rv;
    redirect_pc       = rpc;
    #1;
    fv   = (mq.size() != 0);
    popq = fv && fr && !rv;
    pred = popq && po;
    anyr = rv || pred;
    reqv = !m_inflight && (mq.size() < DEPTH) && !anyr;
    obs_req_v = imem_req_valid;
    obs_addr  = imem_req_addr;
    obs_fv    = fetch_valid;
    obs_fpc   = fetch_pc;
    obs_ins   = fetch_instruction;
    chk("req_valid", obs_req_v, reqv);
    if (reqv) chk("req_addr", obs_addr, m_pc);
    chk("fetch_valid", obs_fv, fv);
    if (fv) begin
      chk("fetch_pc", obs_fpc, mq[0].pc);
      chk("fetch_instr", obs_ins, mq[0].ins);
    end
`ifdef FETCH_PERF_CTR_EN
    chk("perf_fetched", perf_fetched, sat32(m_fetched));
    chk("perf_redirects", perf_redirects, sat32(m_redirs));
`endif
    pushq = 1'b0;
    if (m_inflight && rsp) begin
      pushq      = m_keep && !anyr;
      m_inflight = 1'b0;
    end else if (m_inflight && anyr) begin
      m_keep = 1'b0;
    end
    if (anyr) mq.delete();
    else if (popq) void'(mq.pop_front());
    if (pushq) mq.push_back('{m_out_addr, dat});
    if (popq) m_fetched++;
    if (anyr) m_redirs++;
    if (rv) m_pc = rpc & ~64'd3;
    else if (pred) m_pc = ppc & ~64'd3;
    else if (reqv && rr) begin
      m_out_addr = m_pc;
      m_pc       = m_pc + 64'd4;
      m_inflight = 1'b1;
      m_keep     = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset             = 1'b1;
    imem_req_ready    = 1'b0;
    imem_resp_valid   = 1'b0;
    fetch_ready       = 1'b0;
    pred_overwrite_pc = 1'b0;
    redirect_valid    = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_fetch_valid", fetch_valid, 1'b0);
    chk("rst_fetch_pc", fetch_pc, 64'h0);
    chk("rst_fetch_instr", fetch_instruction, 32'h0);
    chk("rst_req_addr", imem_req_addr, 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Simple stream: memory answers one cycle after each accepted request.
  task automatic run_stream(input int n, input bit fr);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, m_inflight, 32'hA000_0000 + 32'(i), fr, 1'b0, '0, 1'b0, '0);
    end
  endtask

  typedef struct {
    bit            rr;
    bit            rsp;
    bit            fr;
    bit            ereqv;
    logic [AW-1:0] eaddr;
    bit            efv;
    logic [AW-1:0] efpc;
    logic [IW-1:0] eins;
  } vec_t;

  vec_t tbl[7];
  int   issues;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 64'h0, 1'b0, 64'h0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 64'h4, 1'b1, 64'h0, 32'hC0DE_0001};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 64'h8, 1'b1, 64'h4, 32'hC0DE_0003};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 64'hC, 1'b1, 64'h8, 32'hC0DE_0005};

    // In-order fetch of 0x0, 0x4, 0x8 with one-cycle memory.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].rr, tbl[i].rsp, 32'hC0DE_0000 + 32'(i), tbl[i].fr, 1'b0, '0, 1'b0, '0);
      chk("tbl_req_valid", obs_req_v, tbl[i].ereqv);
      if (tbl[i].ereqv) chk("tbl_req_addr", obs_addr, tbl[i].eaddr);
      chk("tbl_fetch_valid", obs_fv, tbl[i].efv);
      if (tbl[i].efv) begin
        chk("tbl_fetch_pc", obs_fpc, tbl[i].efpc);
        chk("tbl_fetch_instr", obs_ins, tbl[i].eins);
      end
    end

    // Decode stalled: exactly two fills, then requests stop until a pop frees a slot.
    do_reset();
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, m_inflight, 32'hB000_0000 + 32'(i), 1'b0, 1'b0, '0, 1'b0, '0);
      if (obs_req_v) issues++;
    end
    chk("fill_issue_count", 64'(issues), 64'd2);
    chk("fill_stalled_req", obs_req_v, 1'b0);
    chk("fill_head_pc", obs_fpc, 64'h0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0);
    chk("full_pop_no_req", obs_req_v, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0);
    chk("resume_req_valid", obs_req_v, 1'b1);
    chk("resume_req_addr", obs_addr, 64'h8);
    chk("resume_head_pc", obs_fpc, 64'h4);

    // Predictor jump at head 0x10 while the 0x14 request is outstanding.
    do_reset();
    run_stream(10, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    chk("pred_head_pc", obs_fpc, 64'h10);
    chk("pred_req_addr_before", obs_addr, 64'h14);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b1, 64'h40, 1'b0, '0);
    chk("pred_no_req_on_jump", obs_req_v, 1'b0);
    cyc(1'b1, 1'b1, 32'hDEAD_0014, 1'b1, 1'b0, '0, 1'b0, '0);
    chk("pred_drop_fetch_valid", obs_fv, 1'b0);
    chk("pred_drop_req_valid", obs_req_v, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0);
    chk("pred_next_req_valid", obs_req_v, 1'b1);
    chk("pred_next_req_addr", obs_addr, 64'h40);
    chk("pred_flushed", obs_fv, 1'b0);

    // Execute redirect to 0x103 coinciding with the response in WAIT.
    do_reset();
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 1'b1, 32'h1111_1111, 1'b1, 1'b0, '0, 1'b1, 64'h103);
    chk("redir_req_valid", obs_req_v, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0);
    chk("redir_resp_discarded", obs_fv, 1'b0);
    chk("redir_next_req_valid", obs_req_v, 1'b1);
    chk("redir_next_req_addr", obs_addr, 64'h100);

    // Execute redirect beats a simultaneous predictor redirect.
    do_reset();
    run_stream(2, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b1, 64'h80, 1'b1, 64'h200);
    chk("both_head_pc", obs_fpc, 64'h0);
    chk("both_req_valid", obs_req_v, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0);
    chk("both_fetch_valid", obs_fv, 1'b0);
    chk("both_next_req_addr", obs_addr, 64'h200);

    // PC wrap at the top of the address space (low bits of the redirect target are cleared).
    do_reset();
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    chk("wrap_req_addr", obs_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(1'b1, 1'b1, 32'h5555_AAAA, 1'b0, 1'b0, '0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    chk("wrap_head_pc", obs_fpc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_next_req_addr", obs_addr, 64'h0);

    // Reset with a request in flight: the late response is ignored.
    do_reset();
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    do_reset();
    cyc(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, '0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    chk("stale_resp_ignored", obs_fv, 1'b0);
    chk("stale_req_addr", obs_addr, 64'h0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 3) != 0,
          m_inflight && ($urandom_range(0, 2) != 0),
          $urandom,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 7) == 0,
          {$urandom, $urandom},
          $urandom_range(0, 19) == 0,
          {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
